init_sequencer: RTL and testbench

INIT_SEQUENCER -- requirements
Module: init_sequencer

---
 rtl/pic_pkg.sv | 46 ++++
 rtl/strobe_sync.sv | 42 ++++
 rtl/init_sequencer.sv | 175 +++++++++++++++++
 tb/tb_init_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// +-----------------------------------------------------------------+
// | pic_pkg: sequencer state encoding and ICW/OCW bit positions.     |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none
package pic_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } seq_state_e;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ADI  = 2;
  localparam int ICW1_LTIM = 3;

  localparam int ICW2_VB_MSB = 7;
  localparam int ICW2_VB_LSB = 3;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

  // Strobe index order used for the synchronizer bank.
  localparam int STB_ICW1   = 0;
  localparam int STB_ICW2_4 = 1;
  localparam int STB_OCW1   = 2;
  localparam int STB_OCW2   = 3;
  localparam int STB_OCW3   = 4;
  localparam int NUM_STB    = 5;

endpackage
`default_nettype wire

// File: rtl/strobe_sync.sv
// +-----------------------------------------------------------------+
// | strobe_sync: multi-flop synchronizer plus rising-edge detector.  |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = strobe_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Valid in the cycle before the consuming edge, so the action lands on edge SYNC_STAGES+1.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/init_sequencer.sv
// +-----------------------------------------------------------------+
// | init_sequencer: ICW1..4 initialization FSM and OCW1..3 handling. |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none
module init_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_ICW_1,
  input  logic       write_ICW2_4,
  input  logic       write_OCW1,
  input  logic       write_OCW2,
  input  logic       write_OCW3,
  input  logic [7:0] internal_bus,
  output logic [2:0] seq_state,
  output logic       init_done,
  output logic       ltim,
  output logic       adi,
  output logic       sngl,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_mode,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic [7:0] ocw2_cmd,
  output logic       ocw2_pulse,
  output logic       read_isr,
  output logic       special_mask,
  output logic       poll_pulse
);

  logic [NUM_STB-1:0] w_stb, w_ev;

  assign w_stb = {write_OCW3, write_OCW2, write_OCW1, write_ICW2_4, write_ICW_1};

  for (genvar g = 0; g < NUM_STB; g++) begin : g_sync
    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .strobe_i(w_stb[g]),
      .rise_o  (w_ev[g])
    );
  end

  seq_state_e state_q, state_d;
  logic       init_done_q, init_done_d;
  logic [3:0] icw1_q, icw1_d;            // {ltim, adi, sngl, ic4}
  logic [4:0] vector_base_q, vector_base_d;
  logic [7:0] cascade_cfg_q, cascade_cfg_d;
  logic [4:0] icw4_q, icw4_d;            // {sfnm, buf_mode, ms, aeoi, upm}
  logic [7:0] imr_q, imr_d;
  logic [7:0] ocw2_cmd_q, ocw2_cmd_d;
  logic       ocw2_pulse_q, ocw2_pulse_d;
  logic       read_isr_q, read_isr_d;
  logic       special_mask_q, special_mask_d;
  logic       poll_pulse_q, poll_pulse_d;

  always_comb begin
    state_d        = state_q;
    icw1_d         = icw1_q;
    vector_base_d  = vector_base_q;
    cascade_cfg_d  = cascade_cfg_q;
    icw4_d         = icw4_q;
    imr_d          = imr_q;
    ocw2_cmd_d     = ocw2_cmd_q;
    ocw2_pulse_d   = 1'b0;
    read_isr_d     = read_isr_q;
    special_mask_d = special_mask_q;
    poll_pulse_d   = 1'b0;

    if (w_ev[STB_ICW1]) begin
      // ICW1 restarts initialization from any state and overrides every other event.
      icw1_d         = internal_bus[3:0];
      imr_d          = 8'h00;
      icw4_d         = 5'b0;
      special_mask_d = 1'b0;
      read_isr_d     = 1'b0;
      state_d        = ST_WAIT_ICW2;
    end else begin
      case (state_q)
        ST_WAIT_ICW2: if (w_ev[STB_ICW2_4]) begin
          vector_base_d = internal_bus[ICW2_VB_MSB:ICW2_VB_LSB];
          if (!icw1_q[ICW1_SNGL])   state_d = ST_WAIT_ICW3;
          else if (icw1_q[ICW1_IC4]) state_d = ST_WAIT_ICW4;
          else                      state_d = ST_READY;
        end
        ST_WAIT_ICW3: if (w_ev[STB_ICW2_4]) begin
          cascade_cfg_d = internal_bus;
          state_d       = icw1_q[ICW1_IC4] ? ST_WAIT_ICW4 : ST_READY;
        end
        ST_WAIT_ICW4: if (w_ev[STB_ICW2_4]) begin
          icw4_d  = internal_bus[4:0];
          state_d = ST_READY;
        end
        ST_READY: begin
          if (w_ev[STB_OCW1]) imr_d = internal_bus;
          if (w_ev[STB_OCW2]) begin
            ocw2_cmd_d   = internal_bus;
            ocw2_pulse_d = 1'b1;
          end
          if (w_ev[STB_OCW3]) begin
            if (internal_bus[OCW3_RR])   read_isr_d     = internal_bus[OCW3_RIS];
            if (internal_bus[OCW3_ESMM]) special_mask_d = internal_bus[OCW3_SMM];
            poll_pulse_d = internal_bus[OCW3_P];
          end
        end
        ST_UNINIT: ;
        default:   state_d = ST_UNINIT;
      endcase
    end

    init_done_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_UNINIT;
      init_done_q    <= 1'b0;
      icw1_q         <= '0;
      vector_base_q  <= '0;
      cascade_cfg_q  <= '0;
      icw4_q         <= '0;
      imr_q          <= '0;
      ocw2_cmd_q     <= '0;
      ocw2_pulse_q   <= 1'b0;
      read_isr_q     <= 1'b0;
      special_mask_q <= 1'b0;
      poll_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_done_q    <= init_done_d;
      icw1_q         <= icw1_d;
      vector_base_q  <= vector_base_d;
      cascade_cfg_q  <= cascade_cfg_d;
      icw4_q         <= icw4_d;
      imr_q          <= imr_d;
      ocw2_cmd_q     <= ocw2_cmd_d;
      ocw2_pulse_q   <= ocw2_pulse_d;
      read_isr_q     <= read_isr_d;
      special_mask_q <= special_mask_d;
      poll_pulse_q   <= poll_pulse_d;
    end
  end

  assign seq_state    = state_q;
  assign init_done    = init_done_q;
  assign ltim         = icw1_q[ICW1_LTIM];
  assign adi          = icw1_q[ICW1_ADI];
  assign sngl         = icw1_q[ICW1_SNGL];
  assign ic4          = icw1_q[ICW1_IC4];
  assign vector_base  = vector_base_q;
  assign cascade_cfg  = cascade_cfg_q;
  assign upm          = icw4_q[ICW4_UPM];
  assign aeoi         = icw4_q[ICW4_AEOI];
  assign ms           = icw4_q[ICW4_MS];
  assign buf_mode     = icw4_q[ICW4_BUF];
  assign sfnm         = icw4_q[ICW4_SFNM];
  assign imr          = imr_q;
  assign ocw2_cmd     = ocw2_cmd_q;
  assign ocw2_pulse   = ocw2_pulse_q;
  assign read_isr     = read_isr_q;
  assign special_mask = special_mask_q;
  assign poll_pulse   = poll_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_init_sequencer.sv
// +-----------------------------------------------------------------+
// | tb_init_sequencer: directed bench for init_sequencer.            |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none
module tb_init_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] stb   = 5'b0;   // {OCW3, OCW2, OCW1, ICW2_4, ICW1}
  logic [7:0] bus   = 8'h00;

  logic [2:0] seq_state;
  logic       init_done, ltim, adi, sngl, ic4;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg;
  logic       upm, aeoi, ms, buf_mode, sfnm;
  logic [7:0] imr, ocw2_cmd;
  logic       ocw2_pulse, read_isr, special_mask, poll_pulse;

  int total = 0;
  int bad   = 0;
  int n_o2  = 0;
  int n_poll = 0;

  always #5 clk = ~clk;

  init_sequencer #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_ICW_1 (stb[0]),
    .write_ICW2_4(stb[1]),
    .write_OCW1  (stb[2]),
    .write_OCW2  (stb[3]),
    .write_OCW3  (stb[4]),
    .internal_bus(bus),
    .seq_state   (seq_state),
    .init_done   (init_done),
    .ltim        (ltim),
    .adi         (adi),
    .sngl        (sngl),
    .ic4         (ic4),
    .vector_base (vector_base),
    .cascade_cfg (cascade_cfg),
    .upm         (upm),
    .aeoi        (aeoi),
    .ms          (ms),
    .buf_mode    (buf_mode),
    .sfnm        (sfnm),
    .imr         (imr),
    .ocw2_cmd    (ocw2_cmd),
    .ocw2_pulse  (ocw2_pulse),
    .read_isr    (read_isr),
    .special_mask(special_mask),
    .poll_pulse  (poll_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n_o2   += int'(ocw2_pulse);
    n_poll += int'(poll_pulse);
  endtask

  // Raise one strobe for `hold` cycles, then let the synchronizer drain.
  task automatic wr(input int idx, input logic [7:0] d, input int hold);
    n_o2   = 0;
    n_poll = 0;
    bus      = d;
    stb[idx] = 1'b1;
    repeat (hold) tick();
    stb[idx] = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(seq_state), 0);
    chk("rst_done",  32'(init_done), 0);
    chk("rst_imr",   32'(imr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // OCW2 before initialization is ignored
    wr(3, 8'h20, 4);
    chk("uninit_o2_pulses", 32'(n_o2), 0);
    chk("uninit_o2_cmd",    32'(ocw2_cmd), 0);
    chk("uninit_state",     32'(seq_state), 0);

    // ICW1=13: action exactly on the third edge
    bus    = 8'h13;
    stb[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("icw1_early_state", 32'(seq_state), 0);
    @(negedge clk);
    chk("icw1_state", 32'(seq_state), 1);
    chk("icw1_fields", 32'({ltim, adi, sngl, ic4}), 4'b0011);
    stb[0] = 1'b0;
    repeat (3) @(negedge clk);

    wr(1, 8'h40, 3);
    chk("icw2_skip_w3", 32'(seq_state), 3);
    chk("icw2_vb",      32'(vector_base), 5'h08);
    chk("w4_not_done",  32'(init_done), 0);
    wr(1, 8'h03, 3);
    chk("icw4_state", 32'(seq_state), 4);
    chk("icw4_fields", 32'({sfnm, buf_mode, ms, aeoi, upm}), 5'b00011);
    chk("ready_done", 32'(init_done), 1);

    // OCW1 held 10 cycles
    bus    = 8'hA5;
    stb[2] = 1'b1;
    repeat (2) @(negedge clk);
    chk("ocw1_early", 32'(imr), 0);
    @(negedge clk);
    chk("ocw1_edge3", 32'(imr), 8'hA5);
    repeat (7) @(negedge clk);
    chk("ocw1_held", 32'(imr), 8'hA5);
    stb[2] = 1'b0;
    repeat (3) @(negedge clk);

    // OCW2 in READY, long strobe -> single pulse
    wr(3, 8'h20, 6);
    chk("ready_o2_pulses", 32'(n_o2), 1);
    chk("ready_o2_cmd",    32'(ocw2_cmd), 8'h20);

    // OCW3
    wr(4, 8'h0B, 3);
    chk("ocw3a_risr",  32'(read_isr), 1);
    chk("ocw3a_smm",   32'(special_mask), 0);
    chk("ocw3a_poll",  32'(n_poll), 0);
    wr(4, 8'h6C, 4);
    chk("ocw3b_risr",  32'(read_isr), 1);
    chk("ocw3b_smm",   32'(special_mask), 1);
    chk("ocw3b_poll",  32'(n_poll), 1);

    // ICW2_4 in READY leaves ICW registers alone
    wr(1, 8'hFF, 3);
    chk("ready_icw2_vb",    32'(vector_base), 5'h08);
    chk("ready_icw2_icw4",  32'({sfnm, buf_mode, ms, aeoi, upm}), 5'b00011);
    chk("ready_icw2_state", 32'(seq_state), 4);

    // Cascaded sequence; ICW1 clears imr/icw4/ocw3 state
    wr(0, 8'h11, 3);
    chk("c_w2",      32'(seq_state), 1);
    chk("c_imr_clr", 32'(imr), 0);
    chk("c_clr",     32'({sfnm, buf_mode, ms, aeoi, upm, special_mask, read_isr}), 0);
    wr(2, 8'h77, 3);
    chk("c_ocw1_ignored", 32'(imr), 0);
    wr(1, 8'h20, 3);
    chk("c_w3", 32'(seq_state), 2);
    chk("c_vb", 32'(vector_base), 5'h04);
    wr(1, 8'h04, 3);
    chk("c_w4",      32'(seq_state), 3);
    chk("c_cascade", 32'(cascade_cfg), 8'h04);
    wr(1, 8'h01, 3);
    chk("c_ready", 32'(seq_state), 4);
    chk("c_icw4",  32'({sfnm, buf_mode, ms, aeoi, upm}), 5'b00001);

    // ICW1 while in WAIT_ICW3 restarts
    wr(2, 8'h3C, 3);
    chk("r_imr", 32'(imr), 8'h3C);
    wr(0, 8'h11, 3);
    chk("r_imr_clr", 32'(imr), 0);
    wr(1, 8'h28, 3);
    chk("r_w3", 32'(seq_state), 2);
    wr(0, 8'h11, 3);
    chk("r_back_w2", 32'(seq_state), 1);
    wr(1, 8'h28, 3);
    wr(1, 8'h02, 3);
    chk("r_w4", 32'(seq_state), 3);

    // Asynchronous reset mid-sequence
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(seq_state), 0);
    chk("arst_cfg", 32'({vector_base, cascade_cfg, ltim, adi, sngl, ic4}), 0);
    chk("arst_done", 32'(init_done), 0);

    // Strobe already high at reset release -> exactly one event
    bus    = 8'h13;
    stb[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_early", 32'(seq_state), 0);
    @(negedge clk);
    chk("rel_event", 32'(seq_state), 1);
    chk("rel_fields", 32'({ltim, adi, sngl, ic4}), 4'b0011);
    stb[0] = 1'b0;
    repeat (3) @(negedge clk);

    // ICW1 and ICW2_4 together: ICW1 wins, vector_base untouched
    bus = 8'h13;
    stb = 5'b00011;
    repeat (3) @(negedge clk);
    stb = 5'b0;
    repeat (3) @(negedge clk);
    chk("simul_state", 32'(seq_state), 1);
    chk("simul_vb",    32'(vector_base), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
